// File: rtl/sap1_pkg.sv
// sap1_pkg: shared opcodes, one-hot T-states and control-word bit positions for the SAP-1 controller.
package sap1_pkg;
  localparam int OPCODE_WIDTH = 4;
  localparam int NUM_T_STATES = 6;
  typedef logic [OPCODE_WIDTH-1:0] opcode_t;
  typedef logic [NUM_T_STATES-1:0] tstate_t;
  localparam opcode_t OP_LDA = 4'b0000;
  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_SUB = 4'b0010;
  localparam opcode_t OP_OUT = 4'b1110;
  localparam opcode_t OP_HLT = 4'b1111;
  localparam tstate_t T1 = 6'b000001;
  localparam tstate_t T2 = 6'b000010;
  localparam tstate_t T3 = 6'b000100;
  localparam tstate_t T4 = 6'b001000;
  localparam tstate_t T5 = 6'b010000;
  localparam tstate_t T6 = 6'b100000;
  localparam int CW_WIDTH = 12;
  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;
endpackage

// File: rtl/ring_counter.sv
// ring_counter: one-hot T-state rotator that resets to T1 and freezes while hold is high.
module ring_counter
  import sap1_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    hold,
  output tstate_t state
);
  always_ff @(posedge clk) begin
    if (reset) state <= T1;
    else if (!hold) state <= {state[NUM_T_STATES-2:0], state[NUM_T_STATES-1]};
  end
endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 control unit; ring counter plus opcode decoder issuing one control word per cycle.
module controller_sequencer
  import sap1_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  opcode_t opcode,
  output tstate_t t_state,
  output logic    cp,
  output logic    ep,
  output logic    lm,
  output logic    ce,
  output logic    li,
  output logic    ei,
  output logic    la,
  output logic    ea,
  output logic    su,
  output logic    eu,
  output logic    lb,
  output logic    lo,
  output logic    hlt
);
  logic halted, halted_next, hlt_now, run;
  logic t1, t2, t3, t4, t5, t6;
  logic is_lda, is_add, is_sub, is_out, is_hlt, mem_op, alu_op;
  assign {t6, t5, t4, t3, t2, t1} = t_state;
  // Opcode compares are always ANDed with a T4..T6 bit, so X opcodes in fetch stay masked.
  assign is_lda = opcode == OP_LDA;
  assign is_add = opcode == OP_ADD;
  assign is_sub = opcode == OP_SUB;
  assign is_out = opcode == OP_OUT;
  assign is_hlt = opcode == OP_HLT;
  assign mem_op = is_lda | is_add | is_sub;
  assign alu_op = is_add | is_sub;
  assign hlt_now = t4 & is_hlt;
  ring_counter u_ring (
    .clk  (clk),
    .reset(reset),
    .hold (halted_next),
    .state(t_state)
  );
  always_ff @(posedge clk) begin
    if (reset) halted <= 1'b0;
    else halted <= halted_next;
  end
  always_comb begin
    halted_next = halted | hlt_now;
  end
  always_comb begin
    run = !reset && !halted;
    ep  = run & t1;
    lm  = run & (t1 | (t4 & mem_op));
    cp  = run & t2;
    ce  = run & (t3 | (t5 & mem_op));
    li  = run & t3;
    ei  = run & t4 & mem_op;
    la  = run & ((t5 & is_lda) | (t6 & alu_op));
    ea  = run & t4 & is_out;
    lo  = run & t4 & is_out;
    lb  = run & t5 & alu_op;
    eu  = run & t6 & alu_op;
    su  = run & t6 & is_sub;
    hlt = !reset & (halted | hlt_now);
  end
  a_bus_exclusive: assert property (@(posedge clk) $onehot0({ep, ce, ei, ea, eu}));
  a_su_needs_eu: assert property (@(posedge clk) !su || eu);
endmodule

// File: tb/tb_controller_sequencer.sv
// tb_controller_sequencer: directed-step bench for the SAP-1 controller with hand-computed control words.
module tb_controller_sequencer;
  import sap1_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
  logic [11:0] cw;
  int errors = 0;
  int checks = 0;
  int cp_seen = 0;
  int cp_exp = 0;
  int excl_bad = 0;
  localparam logic [11:0] C_NONE  = 12'd0;
  localparam logic [11:0] C_F1    = (12'd1 << CW_EP) | (12'd1 << CW_LM);
  localparam logic [11:0] C_F2    = (12'd1 << CW_CP);
  localparam logic [11:0] C_F3    = (12'd1 << CW_CE) | (12'd1 << CW_LI);
  localparam logic [11:0] C_EI_LM = (12'd1 << CW_EI) | (12'd1 << CW_LM);
  localparam logic [11:0] C_CE_LA = (12'd1 << CW_CE) | (12'd1 << CW_LA);
  localparam logic [11:0] C_CE_LB = (12'd1 << CW_CE) | (12'd1 << CW_LB);
  localparam logic [11:0] C_EU_LA = (12'd1 << CW_EU) | (12'd1 << CW_LA);
  localparam logic [11:0] C_SUB6  = (12'd1 << CW_SU) | (12'd1 << CW_EU) | (12'd1 << CW_LA);
  localparam logic [11:0] C_OUT4  = (12'd1 << CW_EA) | (12'd1 << CW_LO);
  controller_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .t_state(t_state),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la),
    .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt)
  );
  always #5 clk = ~clk;
  always_comb begin
    cw = '0;
    cw[CW_CP] = cp;
    cw[CW_EP] = ep;
    cw[CW_LM] = lm;
    cw[CW_CE] = ce;
    cw[CW_LI] = li;
    cw[CW_EI] = ei;
    cw[CW_LA] = la;
    cw[CW_EA] = ea;
    cw[CW_SU] = su;
    cw[CW_EU] = eu;
    cw[CW_LB] = lb;
    cw[CW_LO] = lo;
  end
  always @(posedge clk) if (cp === 1'b1) cp_seen++;
  always @(negedge clk) begin
    if (!$onehot0({ep, ce, ei, ea, eu}) || (su && !eu)) excl_bad++;
  end
  task automatic step(input logic [11:0] e_cw, input logic [5:0] e_t, input logic e_hlt, input string tag);
    #1;
    checks++;
    assert (cw === e_cw) else begin errors++; $error("FAIL %s cw=%b expected=%b", tag, cw, e_cw); end
    checks++;
    assert (t_state === e_t) else begin errors++; $error("FAIL %s t_state=%b expected=%b", tag, t_state, e_t); end
    checks++;
    assert (hlt === e_hlt) else begin errors++; $error("FAIL %s hlt=%b expected=%b", tag, hlt, e_hlt); end
    if (e_cw == C_F2) cp_exp++;
    @(negedge clk);
  endtask
  task automatic fetch(input string tag);
    opcode = 4'bxxxx;
    step(C_F1, T1, 1'b0, {tag, "_t1"});
    step(C_F2, T2, 1'b0, {tag, "_t2"});
    step(C_F3, T3, 1'b0, {tag, "_t3"});
  endtask
  task automatic run_instr(input logic [3:0] op, input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6, input string tag);
    fetch(tag);
    opcode = op;
    step(e4, T4, 1'b0, {tag, "_t4"});
    step(e5, T5, 1'b0, {tag, "_t5"});
    step(e6, T6, 1'b0, {tag, "_t6"});
  endtask
  initial begin
    reset = 1'b1;
    opcode = OP_LDA;
    @(posedge clk);
    @(negedge clk);
    step(C_NONE, T1, 1'b0, "reset_a");
    step(C_NONE, T1, 1'b0, "reset_b");
    reset = 1'b0;
    run_instr(OP_LDA, C_EI_LM, C_CE_LA, C_NONE, "lda");
    run_instr(OP_ADD, C_EI_LM, C_CE_LB, C_EU_LA, "add");
    run_instr(OP_SUB, C_EI_LM, C_CE_LB, C_SUB6, "sub");
    run_instr(OP_OUT, C_OUT4, C_NONE, C_NONE, "out");
    run_instr(4'b0111, C_NONE, C_NONE, C_NONE, "nop");
    fetch("hlt");
    opcode = OP_HLT;
    step(C_NONE, T4, 1'b1, "hlt_t4");
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom_range(0, 15));
      step(C_NONE, T4, 1'b1, "halted");
    end
    reset = 1'b1;
    step(C_NONE, T4, 1'b0, "halt_reset");
    reset = 1'b0;
    opcode = OP_ADD;
    step(C_F1, T1, 1'b0, "post_halt_t1");
    step(C_F2, T2, 1'b0, "mid_t2");
    step(C_F3, T3, 1'b0, "mid_t3");
    step(C_EI_LM, T4, 1'b0, "mid_t4");
    reset = 1'b1;
    step(C_NONE, T5, 1'b0, "mid_reset_t5");
    reset = 1'b0;
    step(C_F1, T1, 1'b0, "mid_after");
    checks++;
    assert (cp_seen === cp_exp) else begin errors++; $error("FAIL cp_count got=%0d expected=%0d", cp_seen, cp_exp); end
    checks++;
    assert (excl_bad === 0) else begin errors++; $error("FAIL bus_exclusive violations=%0d expected=0", excl_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
